// File: rtl/serial_seq_tx.sv
// Serial pattern transmitter: sends a captured WIDTH-bit pattern MSB first,
// repeated repeat_cnt+1 times with GAP idle cycles between passes, then pulses done.
module serial_seq_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       repeat_cnt,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BIT_ONE  = CW'(1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam bit            HAS_GAP  = (GAP > 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_r,     state_s;
  logic [WIDTH-1:0] shift_r,     shift_s;
  logic [WIDTH-1:0] copy_r,      copy_s;
  logic [CW-1:0]    bit_cnt_r,   bit_cnt_s;
  logic [3:0]       rep_left_r,  rep_left_s;
  logic [3:0]       gap_cnt_r,   gap_cnt_s;
  logic             out_r,       out_s;
  logic             out_valid_r, out_valid_s;
  logic             busy_r,      busy_s;
  logic             done_r,      done_s;

  // Next-state and next-output decode; shift_r[WIDTH-1] is the bit on out this cycle.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    copy_s      = copy_r;
    bit_cnt_s   = bit_cnt_r;
    rep_left_s  = rep_left_r;
    gap_cnt_s   = gap_cnt_r;
    out_s       = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start && !abort) begin
          shift_s     = pattern;
          copy_s      = pattern;
          rep_left_s  = repeat_cnt;
          bit_cnt_s   = '0;
          gap_cnt_s   = 4'd0;
          state_s     = S_SHIFT;
          out_s       = pattern[WIDTH-1];
          out_valid_s = 1'b1;
          busy_s      = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_s   = S_IDLE;
          bit_cnt_s = '0;
        end else if (bit_cnt_r != BIT_LAST) begin
          shift_s     = {shift_r[WIDTH-2:0], 1'b0};
          bit_cnt_s   = bit_cnt_r + BIT_ONE;
          out_s       = shift_r[WIDTH-2];
          out_valid_s = 1'b1;
          busy_s      = 1'b1;
        end else if (rep_left_r == 4'd0) begin
          state_s   = S_DONE;
          bit_cnt_s = '0;
          done_s    = 1'b1;
        end else begin
          rep_left_s = rep_left_r - 4'd1;
          bit_cnt_s  = '0;
          busy_s     = 1'b1;
          if (HAS_GAP) begin
            state_s   = S_GAP;
            gap_cnt_s = 4'd0;
          end else begin
            // Zero gap: next pass starts straight from the captured copy.
            state_s     = S_SHIFT;
            shift_s     = copy_r;
            out_s       = copy_r[WIDTH-1];
            out_valid_s = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_s   = S_IDLE;
          gap_cnt_s = 4'd0;
        end else if (gap_cnt_r == GAP_LAST) begin
          state_s     = S_SHIFT;
          gap_cnt_s   = 4'd0;
          shift_s     = copy_r;
          out_s       = copy_r[WIDTH-1];
          out_valid_s = 1'b1;
          busy_s      = 1'b1;
        end else begin
          gap_cnt_s = gap_cnt_r + 4'd1;
          busy_s    = 1'b1;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      shift_r     <= '0;
      copy_r      <= '0;
      bit_cnt_r   <= '0;
      rep_left_r  <= 4'd0;
      gap_cnt_r   <= 4'd0;
      out_r       <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      copy_r      <= copy_s;
      bit_cnt_r   <= bit_cnt_s;
      rep_left_r  <= rep_left_s;
      gap_cnt_r   <= gap_cnt_s;
      out_r       <= out_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_serial_seq_tx.sv
// Scoreboard bench for serial_seq_tx: one instance with GAP=2, one with GAP=0.
// Expected output vectors {out,out_valid,busy,done} are queued with their cycle stamps.
module tb_serial_seq_tx;

  typedef struct packed {
    int         cyc;
    logic [3:0] v;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_a, start_b, abort;
  logic [7:0] pattern;
  logic [3:0] repeat_cnt;
  logic       out_a, valid_a, busy_a, done_a;
  logic       out_b, valid_b, busy_b, done_b;

  ev_t qa[$];
  ev_t qb[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  base;

  serial_seq_tx #(.WIDTH(8), .GAP(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .abort(abort),
    .out(out_a), .out_valid(valid_a), .busy(busy_a), .done(done_a)
  );

  serial_seq_tx #(.WIDTH(8), .GAP(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .abort(abort),
    .out(out_b), .out_valid(valid_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic note(input string nm, input int exp_cyc, input logic [3:0] exp_v,
                      input int got_cyc, input logic [3:0] got_v);
    n_tests++;
    if (exp_cyc != got_cyc || exp_v !== got_v) begin
      n_fail++;
      $display("FAIL %s: got cycle %0d {out,valid,busy,done}=%b, required cycle %0d %b",
               nm, got_cyc, got_v, exp_cyc, exp_v);
    end
  endtask

  task automatic mon_step(input bit sel, input logic [3:0] v);
    ev_t e;
    int  sz;
    sz = sel ? qb.size() : qa.size();
    if (v != 4'b0000) begin
      if (sz == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mon_%0d_unexpected: got cycle %0d vec=%b, required no activity", sel, cyc, v);
      end else begin
        e = sel ? qb.pop_front() : qa.pop_front();
        note(sel ? "mon_b" : "mon_a", e.cyc, e.v, cyc, v);
      end
    end else if (sz != 0) begin
      e = sel ? qb[0] : qa[0];
      if (e.cyc <= cyc) begin
        e = sel ? qb.pop_front() : qa.pop_front();
        note(sel ? "mon_b_missing" : "mon_a_missing", e.cyc, e.v, cyc, v);
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(1'b0, {out_a, valid_a, busy_a, done_a});
    mon_step(1'b1, {out_b, valid_b, busy_b, done_b});
  end

  task automatic push(input bit sel, input int c, input logic [3:0] v);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  task automatic push_pass(input bit sel, input int b, input logic [7:0] p,
                           input int n, input int g);
    for (int k = 0; k <= n; k++) begin
      for (int i = 0; i < 8; i++)
        push(sel, b + k * (8 + g) + i, {p[7 - i], 3'b110});
      if (k < n)
        for (int j = 0; j < g; j++)
          push(sel, b + k * (8 + g) + 8 + j, 4'b0010);
    end
    push(sel, b + (n + 1) * 8 + n * g, 4'b0001);
  endtask

  task automatic start_pass(input bit sel, input logic [7:0] p, input logic [3:0] n,
                            input int g, input bit full, output int b);
    @(negedge clk);
    pattern    = p;
    repeat_cnt = n;
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    b = cyc + 1;
    if (full) push_pass(sel, b, p, int'(n), g);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic check_idle(input string nm);
    logic [7:0] got;
    got = {out_a, valid_a, busy_a, done_a, out_b, valid_b, busy_b, done_b};
    n_tests++;
    if (got !== 8'h00) begin
      n_fail++;
      $display("FAIL %s: outputs a/b=%b, required 00000000", nm, got);
    end
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: pending events a=%0d b=%0d, required 0 0", nm, qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset      = 1'b0;
    start_a    = 1'b0;
    start_b    = 1'b0;
    abort      = 1'b0;
    pattern    = 8'h00;
    repeat_cnt = 4'd0;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single pass, then repeat with gap, then back-to-back with no gap.
    start_pass(1'b0, 8'b10110010, 4'd0, 2, 1'b1, base);
    drain("single");
    start_pass(1'b0, 8'hA5, 4'd1, 2, 1'b1, base);
    drain("gap");
    start_pass(1'b1, 8'hF0, 4'd2, 0, 1'b1, base);
    drain("b2b");

    // Abort at edge 4 of a pass, fresh start at edge 6.
    start_pass(1'b0, 8'hFF, 4'd0, 2, 1'b0, base);
    for (int i = 0; i < 4; i++) push(1'b0, base + i, 4'b1110);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start_pass(1'b0, 8'h81, 4'd0, 2, 1'b1, base);
    drain("abort_shift");

    // Abort during the first gap cycle.
    start_pass(1'b0, 8'hA5, 4'd1, 2, 1'b0, base);
    for (int i = 0; i < 8; i++) push(1'b0, base + i, {((8'hA5 >> (7 - i)) & 8'h01) != 8'h00, 3'b110});
    push(1'b0, base + 8, 4'b0010);
    repeat (8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain("abort_gap");

    // Abort together with start in IDLE: nothing may start.
    @(negedge clk);
    start_a = 1'b1;
    start_b = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    abort   = 1'b0;
    repeat (12) @(negedge clk);
    check_idle("abort_wins");

    // Start/pattern changes mid-pass ignored; abort and start in DONE ignored.
    start_pass(1'b0, 8'hFF, 4'd0, 2, 1'b1, base);
    @(negedge clk);
    @(negedge clk);
    start_a    = 1'b1;
    pattern    = 8'h00;
    repeat_cnt = 4'hF;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    abort   = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    abort   = 1'b0;
    start_a = 1'b0;
    drain("ignore");

    // Reset in cycle 5 of a pass clears outputs without waiting for a clock edge.
    start_pass(1'b0, 8'hC3, 4'd0, 2, 1'b0, base);
    push(1'b0, base + 0, 4'b1110);
    push(1'b0, base + 1, 4'b1110);
    push(1'b0, base + 2, 4'b0110);
    push(1'b0, base + 3, 4'b0110);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_idle("reset_async");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_idle("reset_release");

    // First edge after reset release accepts a start.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset      = 1'b1;
    pattern    = 8'h3C;
    repeat_cnt = 4'd0;
    start_a    = 1'b1;
    base       = cyc + 1;
    push_pass(1'b0, base, 8'h3C, 0, 2);
    @(negedge clk);
    start_a = 1'b0;
    drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
